// File: rtl/mesm6_alu_issue.sv
// MESM-6 ALU issue front end: latches one command, holds it until done, drains.
// Optional perf counters perf_ops/perf_busy: define MESM6_ALU_ISSUE_PERF_EN.
`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 5
`endif
`ifndef ALU_NOP
`define ALU_NOP 5'd0
`endif

module mesm6_alu_issue #(
  parameter int TIMEOUT = 255,
  parameter int OPW = `ALU_OP_WIDTH
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           start,
  input  logic [OPW-1:0] cmd_op,
  input  logic           cmd_wy,
  input  logic           cmd_log,
  input  logic           cmd_norm,
  input  logic           cmd_round,
  input  logic [47:0]    cmd_a,
  input  logic [47:0]    cmd_b,
  output logic           ready,
  output logic [47:0]    result,
  output logic           result_valid,
  output logic           err,
  output logic [OPW-1:0] alu_op,
  output logic           alu_wy,
  output logic           alu_log,
  output logic           alu_norm,
  output logic           alu_round,
  output logic [47:0]    alu_a,
  output logic [47:0]    alu_b,
  input  logic [47:0]    alu_acc,
  input  logic           alu_done
`ifdef MESM6_ALU_ISSUE_PERF_EN
  ,
  output logic [31:0]    perf_ops,
  output logic [31:0]    perf_busy
`endif
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [OPW-1:0] OP_NOP = OPW'(`ALU_NOP);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_YWRITE,
    S_DRAIN
  } state_t;

  state_t         state, state_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic           ready_n;
  logic [47:0]    result_n;
  logic           result_valid_n;
  logic           err_n;
  logic [OPW-1:0] alu_op_n;
  logic           alu_wy_n;
  logic           alu_log_n;
  logic           alu_norm_n;
  logic           alu_round_n;
  logic [47:0]    alu_a_n;
  logic [47:0]    alu_b_n;

  always_comb begin
    state_n        = state;
    cnt_n          = cnt;
    ready_n        = ready;
    result_n       = result;
    result_valid_n = 1'b0;
    err_n          = 1'b0;
    alu_op_n       = alu_op;
    alu_wy_n       = 1'b0;
    alu_log_n      = alu_log;
    alu_norm_n     = alu_norm;
    alu_round_n    = alu_round;
    alu_a_n        = alu_a;
    alu_b_n        = alu_b;
    unique case (state)
      S_IDLE: begin
        ready_n  = 1'b1;
        alu_op_n = OP_NOP;
        if (start) begin
          alu_log_n   = cmd_log;
          alu_norm_n  = cmd_norm;
          alu_round_n = cmd_round;
          alu_a_n     = cmd_a;
          alu_b_n     = cmd_b;
          cnt_n       = '0;
          if (cmd_op != OP_NOP) begin
            alu_op_n = cmd_op;
            ready_n  = 1'b0;
            state_n  = S_RUN;
          end else if (cmd_wy) begin
            alu_wy_n = 1'b1;
            ready_n  = 1'b0;
            state_n  = S_YWRITE;
          end
        end
      end
      S_RUN: begin
        // done wins over the watchdog when both land on the same edge
        if (alu_done) begin
          result_n       = alu_acc;
          result_valid_n = 1'b1;
          alu_op_n       = OP_NOP;
          state_n        = S_DRAIN;
        end else if (cnt == CNT_LAST) begin
          result_n       = '0;
          result_valid_n = 1'b1;
          err_n          = 1'b1;
          alu_op_n       = OP_NOP;
          state_n        = S_DRAIN;
        end else if (cnt != CNT_MAX) begin
          cnt_n = cnt + CW'(1);
        end
      end
      S_YWRITE: begin
        result_n       = alu_a;
        result_valid_n = 1'b1;
        alu_op_n       = OP_NOP;
        ready_n        = 1'b1;
        state_n        = S_IDLE;
      end
      S_DRAIN: begin
        alu_op_n = OP_NOP;
        ready_n  = 1'b1;
        state_n  = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      cnt          <= '0;
      ready        <= 1'b1;
      result       <= '0;
      result_valid <= 1'b0;
      err          <= 1'b0;
      alu_op       <= OP_NOP;
      alu_wy       <= 1'b0;
      alu_log      <= 1'b0;
      alu_norm     <= 1'b0;
      alu_round    <= 1'b0;
      alu_a        <= '0;
      alu_b        <= '0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      ready        <= ready_n;
      result       <= result_n;
      result_valid <= result_valid_n;
      err          <= err_n;
      alu_op       <= alu_op_n;
      alu_wy       <= alu_wy_n;
      alu_log      <= alu_log_n;
      alu_norm     <= alu_norm_n;
      alu_round    <= alu_round_n;
      alu_a        <= alu_a_n;
      alu_b        <= alu_b_n;
    end
  end

`ifdef MESM6_ALU_ISSUE_PERF_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      perf_ops  <= '0;
      perf_busy <= '0;
    end else begin
      if (result_valid) perf_ops <= perf_ops + 32'd1;
      if (!ready) perf_busy <= perf_busy + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mesm6_alu_issue.sv
// Scoreboard bench for mesm6_alu_issue with a behavioural ALU stub.
// Directed scenarios first, then randomized commands, busy starts and resets.
`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 5
`endif
`ifndef ALU_NOP
`define ALU_NOP 5'd0
`endif
`ifndef ALU_AND
`define ALU_AND 5'd1
`endif
`ifndef ALU_ADD_CARRY_AROUND
`define ALU_ADD_CARRY_AROUND 5'd2
`endif
`ifndef ALU_FDIV
`define ALU_FDIV 5'd3
`endif

module tb_mesm6_alu_issue;
  localparam int TO = 8;
  localparam int OPW = `ALU_OP_WIDTH;
  localparam logic [OPW-1:0] OP_NOP  = OPW'(`ALU_NOP);
  localparam logic [OPW-1:0] OP_AND  = OPW'(`ALU_AND);
  localparam logic [OPW-1:0] OP_ARX  = OPW'(`ALU_ADD_CARRY_AROUND);
  localparam logic [OPW-1:0] OP_FDIV = OPW'(`ALU_FDIV);
  localparam logic [OPW-1:0] OP_OR   = OPW'(4);
  localparam logic [OPW-1:0] OP_XOR  = OPW'(5);
  localparam logic [OPW-1:0] OP_ADD  = OPW'(6);
  localparam logic [OPW-1:0] OP_MUL  = OPW'(7);
  localparam logic [OPW-1:0] OP_HANG = OPW'(8);

  logic clk = 1'b0;
  logic reset_n, start, cmd_wy, cmd_log, cmd_norm, cmd_round;
  logic [OPW-1:0] cmd_op;
  logic [47:0] cmd_a, cmd_b;
  logic ready, result_valid, err;
  logic [47:0] result;
  logic [OPW-1:0] alu_op;
  logic alu_wy, alu_log, alu_norm, alu_round;
  logic [47:0] alu_a, alu_b;
  logic [47:0] stub_acc = '0;
  logic stub_done = 1'b0;
  int stub_cnt = 0;
`ifdef MESM6_ALU_ISSUE_PERF_EN
  logic [31:0] perf_ops, perf_busy;
`endif

  mesm6_alu_issue #(.TIMEOUT(TO), .OPW(OPW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .cmd_op(cmd_op), .cmd_wy(cmd_wy), .cmd_log(cmd_log),
    .cmd_norm(cmd_norm), .cmd_round(cmd_round),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .ready(ready), .result(result),
    .result_valid(result_valid), .err(err),
    .alu_op(alu_op), .alu_wy(alu_wy), .alu_log(alu_log),
    .alu_norm(alu_norm), .alu_round(alu_round),
    .alu_a(alu_a), .alu_b(alu_b),
    .alu_acc(stub_acc), .alu_done(stub_done)
`ifdef MESM6_ALU_ISSUE_PERF_EN
    , .perf_ops(perf_ops), .perf_busy(perf_busy)
`endif
  );

  always #5 clk = ~clk;

  function automatic int alu_lat(input logic [OPW-1:0] op);
    if (op == OP_AND || op == OP_OR || op == OP_XOR) return 1;
    if (op == OP_ARX) return 2;
    if (op == OP_ADD) return 5;
    if (op == OP_FDIV) return TO - 1;
    if (op == OP_MUL) return TO;
    return 1000;
  endfunction

  function automatic logic [47:0] ref_res(
    input logic [OPW-1:0] op, input logic [47:0] a, input logic [47:0] b);
    logic [48:0] s;
    logic [47:0] r;
    s = {1'b0, a} + {1'b0, b};
    r = '0;
    if (op == OP_AND) r = a & b;
    else if (op == OP_OR) r = a | b;
    else if (op == OP_XOR) r = a ^ b;
    else if (op == OP_ARX) r = s[47:0] + 48'(s[48]);
    else if (op == OP_ADD) r = s[47:0];
    else if (op == OP_FDIV) r = a ^ {b[23:0], b[47:24]};
    else if (op == OP_MUL) r = 48'(a * b);
    return r;
  endfunction

  function automatic logic [47:0] rand48();
    return {16'($urandom), $urandom};
  endfunction

  function automatic logic [OPW-1:0] pick(input int i);
    case (i)
      0: return OP_NOP;
      1: return OP_AND;
      2: return OP_OR;
      3: return OP_XOR;
      4: return OP_ARX;
      5: return OP_ADD;
      6: return OP_FDIV;
      7: return OP_MUL;
      default: return OP_HANG;
    endcase
  endfunction

  // ALU stub: done rises lat cycles after op appears, cleared by a NOP
  always @(posedge clk) begin
    if (alu_op == OP_NOP) begin
      stub_done <= 1'b0;
      stub_cnt <= 0;
    end else if (!stub_done) begin
      stub_cnt <= stub_cnt + 1;
      if (stub_cnt + 1 == alu_lat(alu_op)) begin
        stub_done <= 1'b1;
        stub_acc <= ref_res(alu_op, alu_a, alu_b);
      end
    end
  end

  typedef struct {
    logic [47:0] res;
    logic err;
    int vcyc;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int cyc = 0;
  int ready_at = 0;
  int total = 0;
  int bad = 0;
  int m_busy = 0;
  int m_ops = 0;
  logic mon_en = 1'b0;
  logic [47:0] hold = '0;
  logic [OPW-1:0] cur_op = '0;
  logic cur_wy = 1'b0;
  logic [2:0] cur_fl = '0;
  logic [47:0] cur_a = '0, cur_b = '0;
  logic busy, vdue;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h cyc=%0d", nm, act, req, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      if (q.size() > 0 && q[0].vcyc < cyc) begin
        total++;
        bad++;
        $display("FAIL missing_valid actual=none required=cyc%0d", q[0].vcyc);
        void'(q.pop_front());
      end
      busy = cyc < ready_at;
      vdue = q.size() > 0 && q[0].vcyc == cyc;
      chk("ready", 64'(ready), 64'(!busy));
      chk("result_valid", 64'(result_valid), 64'(vdue));
      if (result_valid) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_valid actual=1 required=0 cyc=%0d", cyc);
        end else begin
          e = q.pop_front();
          chk("result", 64'(result), 64'(e.res));
          chk("err", 64'(err), 64'(e.err));
          chk("latency", 64'(cyc), 64'(e.vcyc));
          hold = e.res;
          m_ops++;
        end
        chk("drain_op", 64'(alu_op), 64'(OP_NOP));
      end else begin
        chk("result_hold", 64'(result), 64'(hold));
        chk("err_idle", 64'(err), 64'(0));
      end
      if (!busy) begin
        chk("idle_op", 64'(alu_op), 64'(OP_NOP));
        chk("idle_wy", 64'(alu_wy), 64'(0));
      end else if (!vdue) begin
        chk("hold_a", 64'(alu_a), 64'(cur_a));
        if (cur_wy) begin
          chk("ywr_wy", 64'(alu_wy), 64'(1));
          chk("ywr_op", 64'(alu_op), 64'(OP_NOP));
        end else begin
          chk("run_op", 64'(alu_op), 64'(cur_op));
          chk("run_wy", 64'(alu_wy), 64'(0));
          chk("hold_b", 64'(alu_b), 64'(cur_b));
          chk("hold_fl", 64'({alu_log, alu_norm, alu_round}), 64'(cur_fl));
        end
      end
`ifdef MESM6_ALU_ISSUE_PERF_EN
      chk("perf_ops", 64'(perf_ops), 64'(32'(m_ops)));
      chk("perf_busy", 64'(perf_busy), 64'(32'(m_busy)));
`endif
      if (busy) m_busy++;
    end
  end

  task automatic issue(input logic [OPW-1:0] op, input logic wy,
                       input logic [47:0] a, input logic [47:0] b);
    int k, l;
    exp_t x;
    while (cyc < ready_at) begin
      start = 1'($urandom % 2);
      cmd_op = OPW'($urandom_range(1, 8));
      cmd_wy = 1'($urandom);
      cmd_a = rand48();
      @(negedge clk);
    end
    start = 1'b1;
    cmd_op = op;
    cmd_wy = wy;
    cmd_a = a;
    cmd_b = b;
    {cmd_log, cmd_norm, cmd_round} = 3'($urandom);
    k = cyc + 1;
    cur_op = op;
    cur_wy = (op == OP_NOP);
    cur_a = a;
    cur_b = b;
    cur_fl = {cmd_log, cmd_norm, cmd_round};
    if (op != OP_NOP) begin
      l = alu_lat(op);
      if (l <= TO - 1) begin
        x.res = ref_res(op, a, b); x.err = 1'b0; x.vcyc = k + l + 1;
      end else begin
        x.res = '0; x.err = 1'b1; x.vcyc = k + TO;
      end
      q.push_back(x);
      ready_at = x.vcyc + 1;
    end else if (wy) begin
      x.res = a; x.err = 1'b0; x.vcyc = k + 1;
      q.push_back(x);
      ready_at = k + 1;
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    start = 1'b1;
    cmd_op = OP_AND;
    q.delete();
    ready_at = cyc + 1;
    hold = '0;
    m_busy = 0;
    m_ops = 0;
    @(negedge clk);
    reset_n = 1'b1;
    start = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int n;
    reset_n = 1'b0; start = 1'b0; cmd_op = OP_NOP; cmd_wy = 1'b0;
    cmd_log = 1'b0; cmd_norm = 1'b0; cmd_round = 1'b0;
    cmd_a = '0; cmd_b = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(ready), 64'(1));
    chk("rst_result", 64'(result), 64'(0));
    chk("rst_valid", 64'(result_valid), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    chk("rst_op", 64'(alu_op), 64'(OP_NOP));
    chk("rst_ab", 64'({alu_a, alu_wy}), 64'(0));
    ready_at = cyc;
    reset_n = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    issue(OP_AND, 1'b0, 48'h0000_0000_0F0F, 48'h0000_0000_00FF);
    issue(OP_ARX, 1'b0, 48'hFFFF_FFFF_FFFF, 48'h0000_0000_0001);
    issue(OP_HANG, 1'b0, rand48(), rand48());
    issue(OP_NOP, 1'b1, 48'h1234_5678_9ABC, rand48());
    issue(OP_FDIV, 1'b0, rand48(), rand48());
    repeat (3) begin
      start = 1'b1;
      cmd_op = OPW'($urandom_range(1, 8));
      @(negedge clk);
    end
    do_reset();
    issue(OP_AND, 1'b0, 48'h0000_0000_0F0F, 48'h0000_0000_00FF);
    issue(OP_MUL, 1'b0, rand48(), rand48());
    repeat (200) begin
      n = $urandom % 100;
      if (n < 3) do_reset();
      else if (n < 10) repeat ($urandom_range(1, 3)) @(negedge clk);
      else begin
        n = $urandom % 9;
        issue(pick(n), 1'($urandom), rand48(), rand48());
      end
    end
    n = 0;
    while (q.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("queue_empty", 64'(q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
